// File: rtl/cpu_exec_ctrl.sv
// Execution controller for the single-cycle RV32 core: gates the core with a
// per-cycle enable and sequences halt, free-run and N-step modes.
module cpu_exec_ctrl #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int STEP_W      = 8,
  parameter int EBREAK_HALT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              bp_en,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   instr,
  input  logic              clr_cnt,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [STEP_W-1:0] step_left
);

  typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

  localparam logic [XLEN-1:0] EBREAK_INSN = XLEN'(32'h00100073);

  localparam logic [2:0] CAUSE_HOST = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_EBRK = 3'd3;
  localparam logic [2:0] CAUSE_STEP = 3'd4;

  state_t             state_q, state_d;
  logic               run_q, step_q;
  logic               mask_q, mask_d;
  logic               halted_q, halted_d;
  logic [2:0]         cause_q, cause_d;
  logic [STEP_W-1:0]  step_left_q, step_left_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic run_rise, step_rise, bp_hit, eb_hit, stop;
  logic [2:0] stop_cause;

  assign run_rise  = run_req & ~run_q;
  assign step_rise = step_req & ~step_q;

  // The mask lets a resume execute the instruction that caused the halt once.
  assign bp_hit = bp_en & (pc == bp_addr) & ~mask_q;
  assign eb_hit = (EBREAK_HALT != 0) & (instr == EBREAK_INSN) & ~mask_q;
  assign stop   = halt_req | bp_hit | eb_hit;

  assign stop_cause = halt_req ? CAUSE_HOST : (bp_hit ? CAUSE_BP : CAUSE_EBRK);

  assign cpu_en = ((state_q == S_RUN) | (state_q == S_STEP)) & ~stop;

  always_comb begin
    state_d     = state_q;
    step_left_d = step_left_q;
    cause_d     = cause_q;
    mask_d      = mask_q;
    if (cpu_en) mask_d = 1'b0;

    case (state_q)
      S_HALT: begin
        if (!halt_req) begin
          if (step_rise) begin
            state_d     = S_STEP;
            step_left_d = (step_n == '0) ? STEP_W'(1) : step_n;
          end else if (run_rise) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_HALT;
          cause_d = stop_cause;
        end
      end
      S_STEP: begin
        if (stop) begin
          state_d = S_HALT;
          cause_d = stop_cause;
        end else if (run_rise) begin
          state_d     = S_RUN;
          step_left_d = '0;
        end else if (step_left_q == STEP_W'(1)) begin
          state_d     = S_HALT;
          cause_d     = CAUSE_STEP;
          step_left_d = '0;
        end else begin
          step_left_d = step_left_q - STEP_W'(1);
        end
      end
      default: state_d = S_HALT;
    endcase

    if (state_d == S_HALT) mask_d = 1'b1;
    halted_d = (state_d == S_HALT);

    cnt_d = cnt_q;
    if (clr_cnt)     cnt_d = '0;
    else if (cpu_en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HALT;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      mask_q      <= 1'b1;
      halted_q    <= 1'b1;
      cause_q     <= 3'd0;
      step_left_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_req;
      step_q      <= step_req;
      mask_q      <= mask_d;
      halted_q    <= halted_d;
      cause_q     <= cause_d;
      step_left_q <= step_left_d;
      cnt_q       <= cnt_d;
    end
  end

  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign instr_cnt  = cnt_q;
  assign step_left  = step_left_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl with a small core PC model and an
// expected-value queue that is filled at stimulus time and drained at checks.
module tb_cpu_exec_ctrl;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [7:0]  step_n = 8'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0;
  logic [31:0] pc;
  logic [31:0] instr = NOP;
  logic        clr_cnt = 1'b0;

  logic        cpu_en, halted;
  logic [2:0]  halt_cause;
  logic [31:0] instr_cnt;
  logic [7:0]  step_left;

  logic        cpu_en0, halted0;
  logic [2:0]  halt_cause0;
  logic [31:0] instr_cnt0;
  logic [7:0]  step_left0;

  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = 32'd0;

  int compared = 0;
  int mismatched = 0;
  int en_seen = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_exec_ctrl #(.XLEN(32), .CNT_W(32), .STEP_W(8), .EBREAK_HALT(1)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .instr(instr), .clr_cnt(clr_cnt), .cpu_en(cpu_en),
    .halted(halted), .halt_cause(halt_cause), .instr_cnt(instr_cnt),
    .step_left(step_left)
  );

  cpu_exec_ctrl #(.XLEN(32), .CNT_W(32), .STEP_W(8), .EBREAK_HALT(0)) dut0 (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .instr(instr), .clr_cnt(clr_cnt), .cpu_en(cpu_en0),
    .halted(halted0), .halt_cause(halt_cause0), .instr_cnt(instr_cnt0),
    .step_left(step_left0)
  );

  // Core model: PC advances by one instruction on every enabled cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst)        pc <= 32'd0;
    else if (pc_set) pc <= pc_set_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("check %-14s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  // Counts the enable of the current cycle, then moves just past the next edge.
  task automatic tick();
    @(negedge clk);
    if (cpu_en) en_seen++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    expect_val("rst_cpu_en", 32'd0);
    compare({31'd0, cpu_en});
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle after reset
    en_seen = 0;
    expect_val("idle_en", 32'd0); expect_val("idle_halted", 32'd1);
    expect_val("idle_cause", 32'd0); expect_val("idle_cnt", 32'd0);
    repeat (10) tick();
    compare(en_seen); compare({31'd0, halted});
    compare({29'd0, halt_cause}); compare(instr_cnt);

    // Step of 3
    step_n = 8'd3; step_req = 1'b1; en_seen = 0;
    expect_val("step_left3", 32'd3); expect_val("step_left2", 32'd2);
    expect_val("step_left1", 32'd1);
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compare({24'd0, step_left});
      tick();
    end
    repeat (4) tick();
    expect_val("step3_en", 32'd3); expect_val("step3_halted", 32'd1);
    expect_val("step3_cause", 32'd4); expect_val("step3_cnt", 32'd3);
    expect_val("step3_left", 32'd0);
    compare(en_seen); compare({31'd0, halted}); compare({29'd0, halt_cause});
    compare(instr_cnt); compare({24'd0, step_left});

    // step_n=0 with step_req held high
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    step_n = 8'd0; step_req = 1'b1; en_seen = 0;
    repeat (5) tick();
    step_req = 1'b0;
    repeat (3) tick();
    expect_val("step0_en", 32'd1); expect_val("step0_cnt", 32'd1);
    compare(en_seen); compare(instr_cnt);

    // Breakpoint at 0x10 while running from 0
    pc_set = 1'b1; pc_set_val = 32'd0; clr_cnt = 1'b1;
    tick();
    pc_set = 1'b0; clr_cnt = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10; run_req = 1'b1; en_seen = 0;
    tick();
    run_req = 1'b0;
    expect_val("run_halted", 32'd0);
    compare({31'd0, halted});
    repeat (10) tick();
    expect_val("bp_en_cnt", 32'd4); expect_val("bp_pc", 32'h10);
    expect_val("bp_halted", 32'd1); expect_val("bp_cause", 32'd2);
    expect_val("bp_cnt", 32'd4);
    compare(en_seen); compare(pc); compare({31'd0, halted});
    compare({29'd0, halt_cause}); compare(instr_cnt);

    // Resume executes the breakpointed instruction and continues
    run_req = 1'b1; en_seen = 0;
    tick();
    run_req = 1'b0;
    repeat (3) tick();
    expect_val("resume_en", 32'd3); expect_val("resume_pc", 32'h1C);
    expect_val("resume_halted", 32'd0); expect_val("resume_cnt", 32'd7);
    compare(en_seen); compare(pc); compare({31'd0, halted}); compare(instr_cnt);

    // EBREAK during RUN: halts dut, ignored by the EBREAK_HALT=0 instance
    instr = EBREAK;
    expect_val("ebrk_cpu_en", 32'd0); expect_val("ebrk0_cpu_en", 32'd1);
    @(negedge clk);
    compare({31'd0, cpu_en}); compare({31'd0, cpu_en0});
    @(posedge clk); #1;
    instr = NOP; bp_en = 1'b0;
    expect_val("ebrk_halted", 32'd1); expect_val("ebrk_cause", 32'd3);
    expect_val("ebrk0_halted", 32'd0);
    compare({31'd0, halted}); compare({29'd0, halt_cause}); compare({31'd0, halted0});
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    expect_val("ebrk0_cause", 32'd1); expect_val("ebrk_cause_hold", 32'd3);
    compare({29'd0, halt_cause0}); compare({29'd0, halt_cause});

    // Host halt from RUN, then step request masked by halt_req
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (2) tick();
    halt_req = 1'b1;
    expect_val("host_cpu_en", 32'd0);
    @(negedge clk);
    compare({31'd0, cpu_en});
    @(posedge clk); #1;
    step_n = 8'd2; step_req = 1'b1; en_seen = 0;
    repeat (3) tick();
    halt_req = 1'b0;
    repeat (3) tick();
    step_req = 1'b0;
    tick();
    expect_val("hreq_en", 32'd0); expect_val("hreq_halted", 32'd1);
    expect_val("hreq_cause", 32'd1);
    compare(en_seen); compare({31'd0, halted}); compare({29'd0, halt_cause});

    // clr_cnt wins over an enabled cycle
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (2) tick();
    clr_cnt = 1'b1;
    expect_val("clr_cpu_en", 32'd1); expect_val("clr_cnt", 32'd0);
    expect_val("clr_cnt_next", 32'd1);
    @(negedge clk);
    compare({31'd0, cpu_en});
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    compare(instr_cnt);
    tick();
    compare(instr_cnt);

    // Asynchronous reset mid-RUN
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    expect_val("arst_cpu_en", 32'd0); expect_val("arst_halted", 32'd1);
    expect_val("arst_cnt", 32'd0); expect_val("arst_cause", 32'd0);
    compare({31'd0, cpu_en}); compare({31'd0, halted});
    compare(instr_cnt); compare({29'd0, halt_cause});
    @(posedge clk); #1;
    rst = 1'b1;
    en_seen = 0;
    repeat (3) tick();
    expect_val("post_rst_en", 32'd0);
    compare(en_seen);

    if (sb.size() != 0) begin
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
